// File: rtl/uart_tx_framed_if.sv
// uart_tx_framed_if: accept handshake between the packetiser (master) and the UART transmitter (slave).
interface uart_tx_framed_if #(
   parameter int DATA_BITS = 8
) ();
   logic                 has_data;
   logic [DATA_BITS-1:0] data_to_send;
   logic                 ready;
   modport master (output has_data, output data_to_send, input ready);
   modport slave (input has_data, input data_to_send, output ready);
endinterface

// File: rtl/uart_tx_framed.sv
// uart_tx_framed: UART transmitter with 5-9 data bits, none/odd/even parity and 1-2 stop bits,
// a ready/valid accept handshake and a one-cycle completion pulse; all outputs registered.
module uart_tx_framed #(
   parameter int CLOCKS_PER_BIT = 434,
   parameter int DATA_BITS      = 8,
   parameter int PARITY_MODE    = 0,
   parameter int STOP_BITS      = 1
) (
   input  logic            clock,
   input  logic            reset_n,
   uart_tx_framed_if.slave bus,
   output logic            sending_bit,
   output logic            is_transmitting,
   output logic            transmission_done
);
   localparam int CW = $clog2(CLOCKS_PER_BIT) < 1 ? 1 : $clog2(CLOCKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   if (CLOCKS_PER_BIT < 2 || CLOCKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("CLOCKS_PER_BIT must be 2..65535");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("DATA_BITS must be 5..9");
   end
   if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("PARITY_MODE must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
   end
   state_t               r_state, w_state_n;
   logic [CW-1:0]        r_cnt, w_cnt_n;
   logic [IW-1:0]        r_idx, w_idx_n;
   logic                 r_stop, w_stop_n;
   logic [DATA_BITS-1:0] r_buf, w_buf_n;
   logic                 r_par, w_par_n;
   logic                 r_ready, r_line, r_busy, r_done;
   logic                 w_line_n, w_done_n;
   logic                 w_accept, w_bit_end, w_last_data, w_last_stop;
   assign w_accept    = bus.has_data && r_ready;
   assign w_bit_end   = r_cnt == CW'(CLOCKS_PER_BIT - 1);
   assign w_last_data = r_idx == IW'(DATA_BITS - 1);
   assign w_last_stop = r_stop == 1'(STOP_BITS - 1);
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_stop  <= 1'b0;
         r_buf   <= '0;
         r_par   <= 1'b0;
         r_ready <= 1'b1;
         r_line  <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_idx   <= w_idx_n;
         r_stop  <= w_stop_n;
         r_buf   <= w_buf_n;
         r_par   <= w_par_n;
         r_ready <= w_state_n == S_IDLE;
         r_line  <= w_line_n;
         r_busy  <= w_state_n != S_IDLE;
         r_done  <= w_done_n;
      end
   end
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_n = S_START;
         S_START:  if (w_bit_end) w_state_n = S_DATA;
         S_DATA:   if (w_bit_end && w_last_data) w_state_n = PARITY_MODE != 0 ? S_PARITY : S_STOP;
         S_PARITY: if (w_bit_end) w_state_n = S_STOP;
         S_STOP:   if (w_bit_end && w_last_stop) w_state_n = S_IDLE;
         default:  w_state_n = S_IDLE;
      endcase
   end
   // Outputs are derived from the next state so the line changes on the very edge that enters a bit.
   always_comb begin
      w_cnt_n  = (r_state == S_IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
      w_idx_n  = r_state != S_DATA ? '0 : w_bit_end ? r_idx + 1'b1 : r_idx;
      w_stop_n = r_state != S_STOP ? 1'b0 : w_bit_end ? ~r_stop : r_stop;
      w_buf_n  = w_accept ? bus.data_to_send : r_buf;
      w_par_n  = w_accept ? (PARITY_MODE == 1 ? ~^bus.data_to_send : ^bus.data_to_send) : r_par;
      w_line_n = w_state_n == S_START ? 1'b0 : w_state_n == S_DATA ? w_buf_n[w_idx_n] :
                 w_state_n == S_PARITY ? w_par_n : 1'b1;
      w_done_n = r_state == S_STOP && w_state_n == S_IDLE;
   end
   assign bus.ready         = r_ready;
   assign sending_bit       = r_line;
   assign is_transmitting   = r_busy;
   assign transmission_done = r_done;
endmodule

// File: tb/tb_uart_tx_framed.sv
// tb_uart_tx_framed: six transmitter configurations checked every cycle against a frame-level model,
// plus directed literal checks of bit patterns, parity, timing, back-to-back and mid-frame reset.
module tb_uart_tx_framed;
   localparam int N = 6;
   function automatic int cpb_of(input int i);
      return i == 4 ? 2 : i == 5 ? 65535 : 4;
   endfunction
   function automatic int db_of(input int i);
      return i == 3 ? 7 : 8;
   endfunction
   function automatic int pm_of(input int i);
      return i == 1 ? 2 : (i == 2 || i == 3) ? 1 : 0;
   endfunction
   function automatic int sb_of(input int i);
      return i == 3 ? 2 : 1;
   endfunction
   function automatic int frame_len(input int i);
      return cpb_of(i) * (1 + db_of(i) + (pm_of(i) != 0 ? 1 : 0) + sb_of(i));
   endfunction
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       hd [N];
   logic [8:0] dat [N];
   wire [N-1:0] line, rdy, busy, done;
   always #5 clock = ~clock;
   for (genvar g = 0; g < N; g++) begin : g_dut
      uart_tx_framed_if #(.DATA_BITS(db_of(g))) bus ();
      assign bus.has_data     = hd[g];
      assign bus.data_to_send = dat[g][db_of(g)-1:0];
      assign rdy[g]           = bus.ready;
      uart_tx_framed #(
         .CLOCKS_PER_BIT(cpb_of(g)),
         .DATA_BITS(db_of(g)),
         .PARITY_MODE(pm_of(g)),
         .STOP_BITS(sb_of(g))
      ) dut (
         .clock(clock),
         .reset_n(reset_n),
         .bus(bus),
         .sending_bit(line[g]),
         .is_transmitting(busy[g]),
         .transmission_done(done[g])
      );
   end
   int checks = 0;
   int errors = 0;
   task automatic chk(input string nm, input int i, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, i, $time, act, exp);
      end
   endtask
   // Frame model: bit k of a frame counted from acceptance, built from the frame layout rules.
   function automatic logic exp_bit(input int i, input int k, input logic [8:0] w);
      logic [8:0] m;
      m = w & ((9'h1 << db_of(i)) - 9'h1);
      if (k == 0) return 1'b0;
      if (k <= db_of(i)) return m[k-1];
      if (pm_of(i) != 0 && k == db_of(i) + 1) return pm_of(i) == 1 ? ~^m : ^m;
      return 1'b1;
   endfunction
   bit         m_busy [N];
   bit         m_done [N];
   int         m_t [N];
   logic [8:0] m_word [N];
   always @(posedge clock or negedge reset_n)
      for (int i = 0; i < N; i++) begin
         if (!reset_n) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
            m_t[i] = 0;
         end else if (m_busy[i]) begin
            m_t[i]++;
            m_done[i] = m_t[i] == frame_len(i);
            if (m_done[i]) m_busy[i] = 1'b0;
         end else begin
            m_done[i] = 1'b0;
            if (hd[i]) begin
               m_busy[i] = 1'b1;
               m_t[i] = 0;
               m_word[i] = dat[i];
            end
         end
      end
   always @(negedge clock)
      for (int i = 0; i < N; i++) begin
         chk("line", i, line[i], m_busy[i] ? exp_bit(i, m_t[i] / cpb_of(i), m_word[i]) : 1'b1);
         chk("ready", i, rdy[i], !m_busy[i]);
         chk("is_tx", i, busy[i], m_busy[i]);
         chk("done", i, done[i], m_done[i]);
      end
   logic cap [0:255];
   int   done_at, done_cnt, rdy_low;
   bit   big_done = 1'b0;
   task automatic send(input int i, input logic [8:0] w);
      @(negedge clock);
      hd[i] = 1'b1;
      dat[i] = w;
      @(negedge clock);
      hd[i] = 1'b0;
   endtask
   task automatic capture(input int i, input int n);
      done_at = -1;
      done_cnt = 0;
      rdy_low = 0;
      for (int k = 0; k < n; k++) begin
         cap[k] = line[i];
         if (done[i]) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (!rdy[i]) rdy_low++;
         @(negedge clock);
      end
   endtask
   function automatic int decode(input int base, input int cpb, input int db);
      int w = 0;
      for (int k = 0; k < db; k++) w |= int'(cap[base + cpb * (k + 1) + 1]) << k;
      return w;
   endfunction
   initial begin
      int n = 0;
      int w = 0;
      wait (reset_n === 1'b1);
      while (line[5] && w < 1000) begin
         w++;
         @(negedge clock);
      end
      while (!line[5] && n < 70000) begin
         n++;
         @(negedge clock);
      end
      chk("big_start_len", 5, n, 65535);
      chk("big_d0", 5, line[5], 1);
      big_done = 1'b1;
   end
   initial begin
      logic [0:9]  e1;
      logic [0:10] e3;
      int          cnt;
      for (int i = 0; i < N; i++) begin
         hd[i] = 1'b0;
         dat[i] = '0;
      end
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b1;
      send(5, 9'h0FF);
      send(0, 9'h0A5);
      capture(0, 45);
      e1 = 10'b0101001011;
      for (int k = 0; k < 10; k++) chk("t1_bit", k, cap[4 * k + 1], e1[k]);
      chk("t1_done_at", 0, done_at, 40);
      chk("t1_done_width", 0, done_cnt, 1);
      chk("t1_ready_low", 0, rdy_low, 40);
      send(1, 9'h007);
      capture(1, 48);
      chk("t2_even_parity", 1, cap[37], 1);
      chk("t2_even_len", 1, done_at, 44);
      send(2, 9'h007);
      capture(2, 48);
      chk("t2_odd_parity", 2, cap[37], 0);
      chk("t2_odd_len", 2, done_at, 44);
      send(3, 9'h055);
      capture(3, 48);
      e3 = 11'b01010101111;
      for (int k = 0; k < 11; k++) chk("t3_bit", k, cap[4 * k + 1], e3[k]);
      cnt = 0;
      for (int k = 36; k < 44; k++) cnt += int'(cap[k]);
      chk("t3_stop_high", 3, cnt, 8);
      chk("t3_done_at", 3, done_at, 44);
      chk("t3_done_width", 3, done_cnt, 1);
      send(4, 9'h0FF);
      capture(4, 25);
      cnt = 0;
      for (int k = 0; k < 20; k++) cnt += int'(!cap[k]);
      chk("t6_start_len", 4, cnt, 2);
      chk("t6_done_at", 4, done_at, 20);
      for (int c = 0; c < 91; c++) begin
         cap[c] = line[0];
         hd[0] = 1'b1;
         dat[0] = 9'((c * 37 + 11) & 255);
         @(negedge clock);
      end
      hd[0] = 1'b0;
      chk("t4_word1", 0, decode(1, 4, 8), 8'h0B);
      chk("t4_word2", 0, decode(42, 4, 8), 8'hF8);
      chk("t4_stop_before_gap", 0, cap[40], 1);
      chk("t4_idle_gap", 0, cap[41], 1);
      chk("t4_next_start", 0, cap[42], 0);
      repeat (50) @(negedge clock);
      for (int k = 0; k < 70000 && !big_done; k++) @(negedge clock);
      chk("big_finished", 5, big_done, 1);
      send(0, 9'h000);
      repeat (17) @(negedge clock);
      chk("t5_line_before_reset", 0, line[0], 0);
      #2 reset_n = 1'b0;
      #1;
      chk("t5_async_line", 0, line[0], 1);
      chk("t5_async_ready", 0, rdy[0], 1);
      chk("t5_async_is_tx", 0, busy[0], 0);
      @(negedge clock);
      #2 reset_n = 1'b1;
      capture(0, 50);
      chk("t5_no_done", 0, done_cnt, 0);
      send(0, 9'h03C);
      capture(0, 45);
      chk("t5_word", 0, decode(0, 4, 8), 8'h3C);
      chk("t5_done_at", 0, done_at, 40);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_framed.md
Name: uart_tx_framed

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Serialises one word per frame: start bit, 5 to 9 data bits LSB first, an optional odd or even parity bit, then 1 or 2 stop bits. Has an explicit ready/valid accept handshake and a strict one-cycle completion pulse. Sits between the sensor-data packetiser and the board TX pin.

Parameters:
CLOCKS_PER_BIT, 434, clock cycles per bit period (clock frequency / baud rate); legal range 2 to 65535.
DATA_BITS, 8, data bits per frame; legal range 5 to 9.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even; any other value is an elaboration error.
STOP_BITS, 1, number of stop bits; legal values 1 and 2.

Ports:
clock  in  1  system clock; all state changes on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
has_data  in  1  request to send; a word is accepted on any rising edge where has_data && ready.
data_to_send  in  DATA_BITS  word to send; sampled only on acceptance.
ready  out  1  high only in IDLE; block can accept a word.
sending_bit  out  1  serial line; idles high.
is_transmitting  out  1  high from the cycle after acceptance until the cycle after the final stop bit ends.
transmission_done  out  1  single-cycle pulse marking frame completion.

Behaviour:
- Reset: one clock and one asynchronous, active-low reset (reset_n). Reset takes effect immediately, independent of clock.
- Reset values: sending_bit=1, ready=1, is_transmitting=0, transmission_done=0, state=IDLE, bit counter=0, bit index=0.
- All outputs are registered.
- States: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT.
- IDLE: sending_bit=1, ready=1.
  - On has_data && ready, latch data_to_send into the shift buffer and compute the parity bit from the latched word.
  - Odd parity: bit = ~^data. Even parity: bit = ^data.
  - Next state START_BIT; ready=0 and is_transmitting=1 from the next cycle.
- Latency: sending_bit goes low on the first cycle after acceptance.
- Bit timing: every bit (start, each data, parity, each stop) holds sending_bit for exactly CLOCKS_PER_BIT cycles.
  - The counter runs 0 to CLOCKS_PER_BIT-1, then clears.
  - Counter width is $clog2(CLOCKS_PER_BIT), minimum 1. No truncation is allowed at any legal value.
- START_BIT: sending_bit=0 for one bit period, then go to DATA_BITS.
- DATA_BITS: sending_bit=buffer[index], index 0 to DATA_BITS-1. After the last bit, go to PARITY_BIT if PARITY_MODE≠0, else STOP_BIT.
- PARITY_BIT: sending_bit=latched parity bit for one bit period, then go to STOP_BIT.
- STOP_BIT: sending_bit=1 for STOP_BITS bit periods, using a stop counter.
  - At the end of the final stop period, go to IDLE.
  - In that same transition set is_transmitting=0, ready=1 and transmission_done=1.
- transmission_done is high for exactly one cycle, the first IDLE cycle, and clears on the next cycle unconditionally.
- Frame length from acceptance edge to done pulse = CLOCKS_PER_BIT × (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) cycles.
- Back-to-back: if has_data is high during the done-pulse cycle (ready=1), the next word is accepted there.
  - The line stays high for exactly one idle cycle between frames, in addition to the stop bits.
- has_data and data_to_send are ignored while ready=0. A held has_data does not re-queue.
- Reset mid-frame: the frame is aborted immediately.
  - sending_bit returns to 1 asynchronously.
  - No transmission_done pulse for the aborted frame.
  - After reset is released, the first accept behaves as from power-up.
- Unused buffer bits (none when DATA_BITS=9) do not exist. The buffer is exactly DATA_BITS wide.

Test Plan:
1. CLOCKS_PER_BIT=4, 8N1, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done pulse 40 cycles after acceptance; ready low for exactly those 40 cycles.
2. 8E1, send 0x07 -> parity bit=1 after D7; 8O1, send 0x07 -> parity bit=0; frame length 44 cycles at CLOCKS_PER_BIT=4.
3. DATA_BITS=7, 7O2, send 0x55 -> data bits 1,0,1,0,1,0,1, parity 1, stop high for 8 cycles; done pulse exactly one cycle wide.
4. has_data held high with data_to_send changing every cycle, 8N1 -> consecutive frames carry the values sampled at each acceptance; exactly one idle-high cycle between frames.
5. reset_n pulsed low at the fourth data bit -> sending_bit=1 in the same cycle, no done pulse, ready=1; a subsequent send of 0x3C is transmitted correctly.
6. CLOCKS_PER_BIT=2 and CLOCKS_PER_BIT=65535, send 0xFF -> every bit lasts exactly the parameter value; no counter wrap.
